// File: rtl/exe_stage.sv
// rtl/exe_stage.sv - MIPS execute stage: holds one instruction until the ALU completes, then hands it to memory.
module exe_stage #(
    parameter int OP_W = 22
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ds_to_es_valid,
    output logic            es_allowin,
    input  logic [OP_W-1:0] ds_alu_op,
    input  logic [31:0]     ds_src1,
    input  logic [31:0]     ds_src2,
    input  logic [4:0]      ds_dest,
    input  logic [31:0]     ds_pc,
    output logic [OP_W-1:0] alu_op,
    output logic [31:0]     alu_src1,
    output logic [31:0]     alu_src2,
    input  logic            exe_complete,
    input  logic [31:0]     alu_result,
    output logic            es_to_ms_valid,
    input  logic            ms_allowin,
    output logic [31:0]     es_result,
    output logic [4:0]      es_dest,
    output logic [31:0]     es_pc,
    output logic            es_fwd_valid,
    output logic [4:0]      es_fwd_dest,
    output logic [31:0]     es_fwd_data,
    output logic [31:0]     es_stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [OP_W-1:0] op_r;
    logic [31:0]     result_r;
    logic            es_valid;
    logic            es_ready_go;
    logic            load;
    logic            capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        es_valid    = (state != EMPTY);
        es_ready_go = (state == DONE) || ((state == BUSY) && exe_complete);
        es_allowin  = (state == EMPTY) || (es_ready_go && ms_allowin);
        load        = ds_to_es_valid && es_allowin;
        capture     = (state == BUSY) && exe_complete && !ms_allowin;
        case (state)
            EMPTY: begin
                if (load) state_next = BUSY;
            end
            BUSY: begin
                if (exe_complete) begin
                    if (ms_allowin) state_next = load ? BUSY : EMPTY;
                    else            state_next = DONE;
                end
            end
            DONE: begin
                if (ms_allowin) state_next = load ? BUSY : EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    // Payload registers; the result is only latched when memory stalls the completion cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_r         <= '0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            es_dest      <= '0;
            es_pc        <= '0;
            result_r     <= '0;
            es_stall_cnt <= '0;
        end else begin
            if (load) begin
                op_r     <= ds_alu_op;
                alu_src1 <= ds_src1;
                alu_src2 <= ds_src2;
                es_dest  <= ds_dest;
                es_pc    <= ds_pc;
            end
            if (capture) begin
                result_r <= alu_result;
            end
            if ((state == BUSY) && !exe_complete && (es_stall_cnt != 32'hFFFF_FFFF)) begin
                es_stall_cnt <= es_stall_cnt + 32'd1;
            end
        end
    end

    // Masking outside BUSY keeps multi-cycle ops from re-issuing and rewriting HI/LO.
    assign alu_op         = (state == BUSY) ? op_r : '0;
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_result      = (state == DONE) ? result_r : alu_result;
    assign es_fwd_valid   = es_valid && es_ready_go && (es_dest != 5'd0);
    assign es_fwd_dest    = es_dest;
    assign es_fwd_data    = es_result;

endmodule

// File: tb/tb_exe_stage.sv
// tb/tb_exe_stage.sv - Directed testbench for exe_stage with a behavioural multi-cycle ALU.
module tb_exe_stage;

    localparam int OP_W    = 22;
    localparam int DIV_LAT = 3;
    localparam int B_ADDU = 0, B_MULT = 1, B_MULTU = 2, B_DIV = 3, B_DIVU = 4, B_MFHI = 5, B_MFLO = 6;
    localparam logic [OP_W-1:0] OP_ADDU  = 22'd1 << B_ADDU;
    localparam logic [OP_W-1:0] OP_MULT  = 22'd1 << B_MULT;
    localparam logic [OP_W-1:0] OP_DIV   = 22'd1 << B_DIV;
    localparam logic [OP_W-1:0] OP_DIVU  = 22'd1 << B_DIVU;
    localparam logic [OP_W-1:0] OP_MFHI  = 22'd1 << B_MFHI;
    localparam logic [OP_W-1:0] OP_MFLO  = 22'd1 << B_MFLO;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ds_to_es_valid = 1'b0;
    logic            es_allowin;
    logic [OP_W-1:0] ds_alu_op = '0;
    logic [31:0]     ds_src1 = '0;
    logic [31:0]     ds_src2 = '0;
    logic [4:0]      ds_dest = '0;
    logic [31:0]     ds_pc = '0;
    logic [OP_W-1:0] alu_op;
    logic [31:0]     alu_src1;
    logic [31:0]     alu_src2;
    logic            exe_complete;
    logic [31:0]     alu_result;
    logic            es_to_ms_valid;
    logic            ms_allowin = 1'b1;
    logic [31:0]     es_result;
    logic [4:0]      es_dest;
    logic [31:0]     es_pc;
    logic            es_fwd_valid;
    logic [4:0]      es_fwd_dest;
    logic [31:0]     es_fwd_data;
    logic [31:0]     es_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exe_stage #(.OP_W(OP_W)) dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_alu_op(ds_alu_op), .ds_src1(ds_src1), .ds_src2(ds_src2),
        .ds_dest(ds_dest), .ds_pc(ds_pc),
        .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .exe_complete(exe_complete), .alu_result(alu_result),
        .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_result(es_result), .es_dest(es_dest), .es_pc(es_pc),
        .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest), .es_fwd_data(es_fwd_data),
        .es_stall_cnt(es_stall_cnt)
    );

    // Behavioural ALU: mult completes one cycle after issue, div after DIV_LAT extra cycles.
    logic [31:0] hi, lo, m_hi, m_lo;
    logic [63:0] prod;
    int          cnt;
    logic        multi;

    always_comb begin
        alu_result   = '0;
        exe_complete = 1'b0;
        m_hi         = hi;
        m_lo         = lo;
        prod         = '0;
        multi        = alu_op[B_MULT] | alu_op[B_MULTU] | alu_op[B_DIV] | alu_op[B_DIVU];
        if (alu_op[B_ADDU]) begin
            alu_result = alu_src1 + alu_src2; exe_complete = 1'b1;
        end else if (alu_op[B_MFHI]) begin
            alu_result = hi; exe_complete = 1'b1;
        end else if (alu_op[B_MFLO]) begin
            alu_result = lo; exe_complete = 1'b1;
        end else if (alu_op[B_MULT] || alu_op[B_MULTU]) begin
            if (alu_op[B_MULT]) prod = {{32{alu_src1[31]}}, alu_src1} * {{32{alu_src2[31]}}, alu_src2};
            else                prod = {32'd0, alu_src1} * {32'd0, alu_src2};
            m_hi = prod[63:32]; m_lo = prod[31:0];
            exe_complete = (cnt == 1);
        end else if ((alu_op[B_DIV] || alu_op[B_DIVU]) && alu_src2 != 0) begin
            if (alu_op[B_DIV]) begin
                m_lo = $signed(alu_src1) / $signed(alu_src2);
                m_hi = $signed(alu_src1) % $signed(alu_src2);
            end else begin
                m_lo = alu_src1 / alu_src2;
                m_hi = alu_src1 % alu_src2;
            end
            alu_result   = m_lo;
            exe_complete = (cnt == DIV_LAT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 0; hi <= '0; lo <= '0;
        end else if (multi && exe_complete) begin
            cnt <= 0; hi <= m_hi; lo <= m_lo;
        end else if (multi) begin
            cnt <= cnt + 1;
        end else begin
            cnt <= 0;
        end
    end

    task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] d, input logic [31:0] pc);
        ds_to_es_valid = 1'b1; ds_alu_op = op; ds_src1 = s1; ds_src2 = s2; ds_dest = d; ds_pc = pc;
    endtask

    task automatic do_reset();
        reset = 1'b1; ds_to_es_valid = 1'b0; ms_allowin = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Issues one single-cycle op (stage must accept it at the next edge) and returns its result.
    task automatic issue_single(input logic [OP_W-1:0] op, output logic [31:0] res, output logic vld);
        drive(op, 32'd0, 32'd0, 5'd2, 32'h100);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
        @(negedge clk);
        res = es_result; vld = es_to_ms_valid;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (es_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin got %b exp 1", es_allowin); end
        checks++; if (es_to_ms_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", es_to_ms_valid); end
        checks++; if (alu_op !== '0) begin errors++; $display("FAIL reset_alu_op got %h exp 0", alu_op); end
        checks++; if (es_fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd got %b exp 0", es_fwd_valid); end
        checks++; if (es_stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", es_stall_cnt); end
        checks++; if ({es_dest, es_pc, alu_src1, alu_src2} !== '0) begin
            errors++; $display("FAIL reset_payload got %h/%h/%h/%h exp 0", es_dest, es_pc, alu_src1, alu_src2);
        end
    endtask

    task automatic test_addu_stream();
        do_reset();
        drive(OP_ADDU, 32'd1, 32'd10, 5'd1, 32'h1000);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i < 3) drive(OP_ADDU, 32'(i + 2), 32'd10, 5'd1, 32'h1000 + 32'((i + 1) * 4));
            else       ds_to_es_valid = 1'b0;
            @(negedge clk);
            checks++; if (es_to_ms_valid !== 1'b1 || es_result !== 32'(11 + i)) begin
                errors++; $display("FAIL stream_result[%0d] got v=%b %0d exp v=1 %0d", i, es_to_ms_valid, es_result, 11 + i);
            end
            checks++; if (es_allowin !== 1'b1 || es_pc !== 32'h1000 + 32'(i * 4)) begin
                errors++; $display("FAIL stream_allowin_pc[%0d] got %b %h exp 1 %h", i, es_allowin, es_pc, 32'h1000 + 32'(i * 4));
            end
        end
        checks++; if (es_stall_cnt !== 32'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", es_stall_cnt); end
    endtask

    task automatic test_mult();
        logic [31:0] r;
        logic        v;
        do_reset();
        drive(OP_MULT, 32'hFFFF_FFFF, 32'd2, 5'd0, 32'h2000);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b0 || alu_op !== OP_MULT) begin
            errors++; $display("FAIL mult_cycle1 got v=%b op=%h exp v=0 op=%h", es_to_ms_valid, alu_op, OP_MULT);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1) begin errors++; $display("FAIL mult_cycle2_valid got %b exp 1", es_to_ms_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (alu_op !== '0 || es_to_ms_valid !== 1'b0) begin
            errors++; $display("FAIL mult_after got op=%h v=%b exp 0 0", alu_op, es_to_ms_valid);
        end
        checks++; if (es_stall_cnt !== 32'd1) begin errors++; $display("FAIL mult_stall got %0d exp 1", es_stall_cnt); end
        issue_single(OP_MFHI, r, v);
        checks++; if (v !== 1'b1 || r !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_mfhi got v=%b %h exp 1 ffffffff", v, r); end
        issue_single(OP_MFLO, r, v);
        checks++; if (v !== 1'b1 || r !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_mflo got v=%b %h exp 1 fffffffe", v, r); end
    endtask

    task automatic test_div_hold();
        logic [31:0] r;
        logic        v;
        int          cycles;
        do_reset();
        ms_allowin = 1'b0;
        drive(OP_DIV, 32'd100, 32'd7, 5'd3, 32'h3000);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            cycles++;
            if (es_to_ms_valid) break;
            @(posedge clk); #1;
        end
        checks++; if (es_to_ms_valid !== 1'b1 || cycles != DIV_LAT + 1) begin
            errors++; $display("FAIL div_occupancy got v=%b cycles=%0d exp 1 %0d", es_to_ms_valid, cycles, DIV_LAT + 1);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++; if (alu_op !== '0 || es_to_ms_valid !== 1'b1 || es_allowin !== 1'b0 || es_result !== 32'd14) begin
                errors++; $display("FAIL div_hold[%0d] got op=%h v=%b a=%b r=%0d exp 0 1 0 14", k, alu_op, es_to_ms_valid, es_allowin, es_result);
            end
        end
        checks++; if (es_stall_cnt !== 32'(DIV_LAT)) begin errors++; $display("FAIL div_stall got %0d exp %0d", es_stall_cnt, DIV_LAT); end
        ms_allowin = 1'b1;
        issue_single(OP_MFLO, r, v);
        checks++; if (v !== 1'b1 || r !== 32'd14) begin errors++; $display("FAIL div_mflo got v=%b %0d exp 1 14", v, r); end
        issue_single(OP_MFHI, r, v);
        checks++; if (v !== 1'b1 || r !== 32'd2) begin errors++; $display("FAIL div_mfhi got v=%b %0d exp 1 2", v, r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [2];
        logic [31:0] r;
        logic        v;
        int          ngot;
        logic        chk_next;
        do_reset();
        drive(OP_DIVU, 32'h8000_0000, 32'd3, 5'd4, 32'h4000);
        @(posedge clk); #1;
        drive(OP_DIVU, 32'd9, 32'd2, 5'd5, 32'h4004);
        ngot = 0; chk_next = 1'b0; got[0] = '0; got[1] = '0;
        for (int c = 0; c < 30 && ngot < 2; c++) begin
            @(negedge clk);
            if (chk_next) begin
                chk_next = 1'b0;
                checks++; if (alu_op !== OP_DIVU || alu_src1 !== 32'd9 || es_to_ms_valid !== 1'b0) begin
                    errors++; $display("FAIL b2b_second_issue got op=%h s1=%0d v=%b exp %h 9 0", alu_op, alu_src1, es_to_ms_valid, OP_DIVU);
                end
            end
            if (es_to_ms_valid) begin
                got[ngot] = es_result;
                if (ngot == 0) chk_next = 1'b1;
                ngot++;
            end
            @(posedge clk); #1;
            if (ngot >= 1) ds_to_es_valid = 1'b0;
        end
        checks++; if (ngot != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", ngot); end
        checks++; if (got[0] !== 32'h2AAA_AAAA || got[1] !== 32'd4) begin
            errors++; $display("FAIL b2b_order got %h %h exp 2aaaaaaa 00000004", got[0], got[1]);
        end
        issue_single(OP_MFLO, r, v);
        checks++; if (v !== 1'b1 || r !== 32'd4) begin errors++; $display("FAIL b2b_lo got v=%b %0d exp 1 4", v, r); end
        issue_single(OP_MFHI, r, v);
        checks++; if (v !== 1'b1 || r !== 32'd1) begin errors++; $display("FAIL b2b_hi got v=%b %0d exp 1 1", v, r); end
    endtask

    task automatic test_forwarding();
        do_reset();
        drive(OP_ADDU, 32'd3, 32'd4, 5'd0, 32'h5000);
        @(posedge clk); #1;
        drive(OP_ADDU, 32'd3, 32'd4, 5'd5, 32'h5004);
        @(negedge clk);
        checks++; if (es_to_ms_valid !== 1'b1 || es_fwd_valid !== 1'b0) begin
            errors++; $display("FAIL fwd_dest0 got v=%b fwd=%b exp 1 0", es_to_ms_valid, es_fwd_valid);
        end
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        @(negedge clk);
        checks++; if (es_fwd_valid !== 1'b1 || es_fwd_dest !== 5'd5 || es_fwd_data !== 32'd7) begin
            errors++; $display("FAIL fwd_dest5 got %b %0d %0d exp 1 5 7", es_fwd_valid, es_fwd_dest, es_fwd_data);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (es_fwd_valid !== 1'b0) begin errors++; $display("FAIL fwd_empty got %b exp 0", es_fwd_valid); end
    endtask

    task automatic test_reset_mid_div();
        do_reset();
        drive(OP_DIV, 32'd50, 32'd5, 5'd6, 32'h6000);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (alu_op !== OP_DIV || es_stall_cnt !== 32'd1) begin
            errors++; $display("FAIL middiv_busy got op=%h stall=%0d exp %h 1", alu_op, es_stall_cnt, OP_DIV);
        end
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (es_allowin !== 1'b1 || es_to_ms_valid !== 1'b0 || es_stall_cnt !== 32'd0 || alu_op !== '0) begin
            errors++; $display("FAIL middiv_reset got a=%b v=%b stall=%0d op=%h exp 1 0 0 0", es_allowin, es_to_ms_valid, es_stall_cnt, alu_op);
        end
    endtask

    initial begin
        test_reset();
        test_addu_stream();
        test_mult();
        test_div_hold();
        test_back_to_back();
        test_forwarding();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
